// File: rtl/bit_load_scheduler.sv
// Serial bit loader: debounced button rises become {bit, target} commands in a
// small FIFO, and a two-state engine shifts each one into register A or B.
module bit_load_scheduler #(
    parameter int WORD  = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_zero,
    input  logic            btn_one,
    input  logic            swich,
    input  logic            clr,
    output logic [WORD-1:0] bus_a,
    output logic [WORD-1:0] bus_b,
    output logic            full_a,
    output logic            full_b,
    output logic            busy,
    output logic            ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WORD + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WORD);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            prev_zero_q, prev_one_q, armed_q;
    logic            cmd_bit_q, cmd_bit_d;
    logic            cmd_tgt_q, cmd_tgt_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [1:0]      mem_q [DEPTH];
    logic [WORD-1:0] bus_a_q, bus_a_d, bus_b_q, bus_b_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic            ovf_q, ovf_d;
    logic            full_a_q, full_b_q, busy_q;

    logic            rise_zero_s, rise_one_s, one_rise_s;
    logic            fifo_empty_s, fifo_full_s, push_s, drop_s;
    logic            clr_a_s, clr_b_s, hit_full_a_s, hit_full_b_s;
    logic [1:0]      head_s;
    logic [WORD-1:0] app_a_s, app_b_s;
    logic [CW-1:0]   app_cnt_a_s, app_cnt_b_s;

    // Edge detection, FIFO bookkeeping and the IDLE/APPLY engine next-state.
    always_comb begin
        // armed_q blocks a rise on the first cycle after reset, so a held button needs a fresh press.
        rise_zero_s  = armed_q & btn_zero & ~prev_zero_q;
        rise_one_s   = armed_q & btn_one  & ~prev_one_q;
        one_rise_s   = rise_zero_s ^ rise_one_s;
        fifo_empty_s = (wr_ptr_q == rd_ptr_q);
        fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_s       = one_rise_s & ~fifo_full_s;
        drop_s       = (rise_zero_s & rise_one_s) | (one_rise_s & fifo_full_s);
        clr_a_s      = clr & ~swich;
        clr_b_s      = clr & swich;
        head_s       = mem_q[rd_ptr_q[AW-1:0]];

        state_d      = state_q;
        cmd_bit_d    = cmd_bit_q;
        cmd_tgt_d    = cmd_tgt_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        app_a_s      = bus_a_q;
        app_b_s      = bus_b_q;
        app_cnt_a_s  = cnt_a_q;
        app_cnt_b_s  = cnt_b_q;
        hit_full_a_s = 1'b0;
        hit_full_b_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    cmd_bit_d = head_s[1];
                    cmd_tgt_d = head_s[0];
                    rd_ptr_d  = rd_ptr_q + PTR_ONE;
                    state_d   = APPLY;
                end else begin
                    state_d   = IDLE;
                end
            end
            APPLY: begin
                state_d = IDLE;
                if (cmd_tgt_q == 1'b0) begin
                    if (cnt_a_q != CNT_MAX) begin
                        app_a_s     = {bus_a_q[WORD-2:0], cmd_bit_q};
                        app_cnt_a_s = cnt_a_q + CNT_ONE;
                    end else begin
                        hit_full_a_s = 1'b1;
                    end
                end else begin
                    if (cnt_b_q != CNT_MAX) begin
                        app_b_s     = {bus_b_q[WORD-2:0], cmd_bit_q};
                        app_cnt_b_s = cnt_b_q + CNT_ONE;
                    end else begin
                        hit_full_b_s = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear overrides an APPLY to the same register, including its overflow.
        bus_a_d = clr_a_s ? {WORD{1'b0}} : app_a_s;
        cnt_a_d = clr_a_s ? {CW{1'b0}}   : app_cnt_a_s;
        bus_b_d = clr_b_s ? {WORD{1'b0}} : app_b_s;
        cnt_b_d = clr_b_s ? {CW{1'b0}}   : app_cnt_b_s;
        ovf_d   = (ovf_q & ~clr) | drop_s |
                  (hit_full_a_s & ~clr_a_s) | (hit_full_b_s & ~clr_b_s);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_zero_q <= 1'b0;
            prev_one_q  <= 1'b0;
            armed_q     <= 1'b0;
            cmd_bit_q   <= 1'b0;
            cmd_tgt_q   <= 1'b0;
            wr_ptr_q    <= {(AW + 1){1'b0}};
            rd_ptr_q    <= {(AW + 1){1'b0}};
            bus_a_q     <= {WORD{1'b0}};
            bus_b_q     <= {WORD{1'b0}};
            cnt_a_q     <= {CW{1'b0}};
            cnt_b_q     <= {CW{1'b0}};
            ovf_q       <= 1'b0;
            full_a_q    <= 1'b0;
            full_b_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_zero_q <= btn_zero;
            prev_one_q  <= btn_one;
            armed_q     <= 1'b1;
            cmd_bit_q   <= cmd_bit_d;
            cmd_tgt_q   <= cmd_tgt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bus_a_q     <= bus_a_d;
            bus_b_q     <= bus_b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            ovf_q       <= ovf_d;
            full_a_q    <= (cnt_a_d == CNT_MAX);
            full_b_q    <= (cnt_b_d == CNT_MAX);
            busy_q      <= (wr_ptr_d != rd_ptr_d) || (state_d != IDLE);
        end
    end

    // Command FIFO storage; the target is the swich value at push time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: 2'b00};
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {rise_one_s, swich};
        end
    end

    assign bus_a  = bus_a_q;
    assign bus_b  = bus_b_q;
    assign full_a = full_a_q;
    assign full_b = full_b_q;
    assign busy   = busy_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_bit_load_scheduler.sv
// Directed bench for bit_load_scheduler: inputs change and outputs are sampled
// on the falling clock edge, away from the rising edge where the DUT updates.
module tb_bit_load_scheduler;

    logic       clk;
    logic       reset;
    logic       btn_zero;
    logic       btn_one;
    logic       swich;
    logic       clr;
    logic [3:0] bus_a;
    logic [3:0] bus_b;
    logic       full_a;
    logic       full_b;
    logic       busy;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    bit_load_scheduler #(.WORD(4), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_zero (btn_zero),
        .btn_one  (btn_one),
        .swich    (swich),
        .clr      (clr),
        .bus_a    (bus_a),
        .bus_b    (bus_b),
        .full_a   (full_a),
        .full_b   (full_b),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle press, then enough idle cycles for push, pop and apply.
    task automatic pulse(input bit one);
        if (one) btn_one = 1'b1;
        else     btn_zero = 1'b1;
        cyc(1);
        btn_one  = 1'b0;
        btn_zero = 1'b0;
        cyc(3);
    endtask

    initial begin
        reset = 1'b0; btn_zero = 1'b0; btn_one = 1'b0; swich = 1'b0; clr = 1'b0;
        cyc(2);
        check("rst_bus_a", bus_a, 4'h0);
        check("rst_bus_b", bus_b, 4'h0);
        check("rst_full",  {full_a, full_b}, 2'b00);
        check("rst_busy",  busy, 1'b0);
        check("rst_ovf",   ovf, 1'b0);
        reset = 1'b1;
        cyc(2);

        // First bit with cycle-accurate latency: push E0, pop E1, visible after E2.
        btn_one = 1'b1;
        cyc(1);
        check("lat_busy_e0", busy, 1'b1);
        check("lat_bus_e0",  bus_a, 4'h0);
        btn_one = 1'b0;
        cyc(1);
        check("lat_bus_e1",  bus_a, 4'h0);
        cyc(1);
        check("lat_bus_e2",  bus_a, 4'h1);
        check("lat_idle",    busy, 1'b0);
        cyc(1);
        pulse(1'b0);
        pulse(1'b1);
        pulse(1'b1);
        check("seq_bus_a",  bus_a, 4'b1011);
        check("seq_full_a", full_a, 1'b1);
        check("seq_bus_b",  bus_b, 4'h0);
        check("seq_ovf",    ovf, 1'b0);

        // Fifth bit into a full A is dropped with ovf.
        pulse(1'b0);
        check("full_bus_a", bus_a, 4'b1011);
        check("full_ovf",   ovf, 1'b1);

        // Another A bit, with clr of A landing on its APPLY edge.
        btn_one = 1'b1;
        cyc(1);
        btn_one = 1'b0;
        cyc(1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("clrapp_bus_a",  bus_a, 4'h0);
        check("clrapp_full_a", full_a, 1'b0);
        check("clrapp_ovf",    ovf, 1'b0);
        cyc(1);
        pulse(1'b1);
        check("after_clr_bus_a", bus_a, 4'h1);

        // Apply to B while clearing A on the same edge.
        swich = 1'b1; btn_one = 1'b1;
        cyc(1);
        btn_one = 1'b0;
        cyc(1);
        swich = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("split_bus_a", bus_a, 4'h0);
        check("split_bus_b", bus_b, 4'h1);
        cyc(1);

        // Target is captured at push time, not at apply time.
        swich = 1'b0; btn_one = 1'b1;
        cyc(1);
        btn_one = 1'b0; swich = 1'b1;
        cyc(3);
        check("retgt_bus_a", bus_a, 4'h1);
        check("retgt_bus_b", bus_b, 4'h1);
        swich = 1'b0;

        // Simultaneous rises are both dropped.
        btn_zero = 1'b1; btn_one = 1'b1;
        cyc(1);
        check("both_busy", busy, 1'b0);
        check("both_ovf",  ovf, 1'b1);
        btn_zero = 1'b0; btn_one = 1'b0;
        cyc(2);
        check("both_bus_a", bus_a, 4'h1);
        check("both_bus_b", bus_b, 4'h1);
        swich = 1'b1; clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("clr_ovf",   ovf, 1'b0);
        check("clr_bus_b", bus_b, 4'h0);
        swich = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("clr_bus_a", bus_a, 4'h0);

        // Burst of alternating rises, one per cycle: bits 1,0,1,0 to A then
        // 1,0,1,0 to B; the eighth push meets a full FIFO and is lost.
        for (int k = 0; k < 8; k++) begin
            btn_one  = (k % 2 == 0);
            btn_zero = (k % 2 == 1);
            swich    = (k >= 4);
            cyc(1);
        end
        btn_one = 1'b0; btn_zero = 1'b0; swich = 1'b0;
        check("burst_busy", busy, 1'b1);
        check("burst_ovf",  ovf, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) break;
            cyc(1);
        end
        check("burst_drain",  busy, 1'b0);
        check("burst_bus_a",  bus_a, 4'b1010);
        check("burst_full_a", full_a, 1'b1);
        check("burst_bus_b",  bus_b, 4'b0101);
        check("burst_full_b", full_b, 1'b0);

        // Fill B, queue another bit, then reset asynchronously mid-APPLY with the button held.
        swich = 1'b1; btn_one = 1'b1;
        cyc(1);
        btn_one = 1'b0;
        cyc(1);
        btn_one = 1'b1;
        cyc(1);
        check("pre_rst_bus_b",  bus_b, 4'b1011);
        check("pre_rst_full_b", full_b, 1'b1);
        check("pre_rst_busy",   busy, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_bus_a", bus_a, 4'h0);
        check("arst_bus_b", bus_b, 4'h0);
        check("arst_full",  {full_a, full_b}, 2'b00);
        check("arst_busy",  busy, 1'b0);
        check("arst_ovf",   ovf, 1'b0);
        cyc(2);
        reset = 1'b1;
        cyc(4);
        check("held_busy",  busy, 1'b0);
        check("held_bus_b", bus_b, 4'h0);
        btn_one = 1'b0;
        cyc(1);
        pulse(1'b1);
        check("repress_bus_b", bus_b, 4'h1);
        check("repress_bus_a", bus_a, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
